// File: rtl/ttt_pkg.sv
// Shared types and line table for the tic-tac-toe controller.
// Cells are row-major, 0 = top-left.
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    MARK_X = 2'b01,
    MARK_O = 2'b10
  } mark_t;

  typedef mark_t [8:0] board_t;

  typedef enum logic [1:0] {
    PLAY  = 2'b00,
    CHECK = 2'b01,
    WIN   = 2'b10,
    DRAW  = 2'b11
  } state_t;

  // One 9-bit cell mask per line, bit i = cell i
  localparam logic [7:0][8:0] WIN_LINES = {
    9'b001010100,
    9'b100010001,
    9'b100100100,
    9'b010010010,
    9'b001001001,
    9'b111000000,
    9'b000111000,
    9'b000000111
  };

  function automatic mark_t flip(mark_t m);
    return (m == MARK_X) ? MARK_O : MARK_X;
  endfunction

endpackage

// File: rtl/ttt_game_ctrl_if.sv
// Move request handshake between a requester and the game controller.
// move_err pulses one cycle after an illegal move is accepted.
interface ttt_game_ctrl_if;

  logic       move_valid;
  logic [3:0] move_cell;
  logic       move_ready;
  logic       move_err;

  modport master (
    output move_valid,
    output move_cell,
    input  move_ready,
    input  move_err
  );

  modport slave (
    input  move_valid,
    input  move_cell,
    output move_ready,
    output move_err
  );

endinterface

// File: rtl/ttt_win_detect.sv
// Combinational line detector: flags every line fully owned by mark.
// mask is the OR of all won lines, so double lines show together.
module ttt_win_detect
  import ttt_pkg::*;
(
  input  board_t      board,
  input  mark_t       mark,
  output logic        win,
  output logic [8:0]  mask
);

  logic [8:0] hit;

  always_comb begin
    hit  = '0;
    win  = 1'b0;
    mask = '0;
    for (int i = 0; i < 9; i++) begin
      hit[i] = (board[i] == mark);
    end
    for (int l = 0; l < 8; l++) begin
      if ((hit & WIN_LINES[l]) == WIN_LINES[l]) begin
        win  = 1'b1;
        mask = mask | WIN_LINES[l];
      end
    end
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe sequencer: move legality, turn order, win/draw detection
// and a blinking winning line on the display board.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter int    BLINK_CYCLES = 25_000_000,
  parameter mark_t FIRST_MARK   = MARK_X
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_game,
  ttt_game_ctrl_if.slave   mv,
  output board_t           board,
  output mark_t            turn,
  output state_t           game_state,
  output mark_t            winner,
  output logic [8:0]       win_mask
);

  localparam int CW = $clog2(BLINK_CYCLES);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_CYCLES - 1);

  state_t        state_q, state_d;
  board_t        board_q, board_d;
  mark_t         turn_q, turn_d;
  mark_t         winner_q, winner_d;
  logic [8:0]    mask_q, mask_d;
  logic          err_q, err_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [CW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;

  logic          line_win;
  logic [8:0]    line_mask;
  logic          legal;

  ttt_win_detect u_win (
    .board (board_q),
    .mark  (turn_q),
    .win   (line_win),
    .mask  (line_mask)
  );

  assign mv.move_ready = (state_q == PLAY) && !new_game;
  assign mv.move_err   = err_q;
  assign turn          = turn_q;
  assign game_state    = state_q;
  assign winner        = winner_q;
  assign win_mask      = mask_q;

  // mask_q is only non-zero in WIN, so blanking applies only there
  always_comb begin
    board = board_q;
    for (int i = 0; i < 9; i++) begin
      if (!phase_q && mask_q[i]) begin
        board[i] = EMPTY;
      end
    end
  end

  always_comb begin
    legal = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (mv.move_cell == 4'(i) && board_q[i] == EMPTY) begin
        legal = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    turn_d   = turn_q;
    winner_d = winner_q;
    mask_d   = mask_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    blink_d  = blink_q;
    phase_d  = phase_q;
    if (new_game) begin
      state_d  = PLAY;
      board_d  = {9{EMPTY}};
      turn_d   = FIRST_MARK;
      winner_d = EMPTY;
      mask_d   = '0;
      cnt_d    = '0;
      blink_d  = '0;
      phase_d  = 1'b1;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (mv.move_valid) begin
            if (legal) begin
              for (int i = 0; i < 9; i++) begin
                if (mv.move_cell == 4'(i)) begin
                  board_d[i] = turn_q;
                end
              end
              cnt_d   = cnt_q + 4'd1;
              state_d = CHECK;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        CHECK: begin
          if (line_win) begin
            state_d  = WIN;
            winner_d = turn_q;
            mask_d   = line_mask;
            blink_d  = '0;
            phase_d  = 1'b1;
          end else if (cnt_q == 4'd9) begin
            state_d = DRAW;
          end else begin
            state_d = PLAY;
            turn_d  = flip(turn_q);
          end
        end
        WIN: begin
          if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            phase_d = !phase_q;
          end else begin
            blink_d = blink_q + CW'(1);
          end
        end
        DRAW: begin
        end
        default: state_d = PLAY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PLAY;
      board_q  <= {9{EMPTY}};
      turn_q   <= FIRST_MARK;
      winner_q <= EMPTY;
      mask_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      blink_q  <= '0;
      phase_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      turn_q   <= turn_d;
      winner_q <= winner_d;
      mask_q   <= mask_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      blink_q  <= blink_d;
      phase_q  <= phase_d;
    end
  end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl with a reference board model and
// an expectation queue popped at each sample point.
module tb_ttt_game_ctrl;
  import ttt_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic new_game;
  board_t board;
  mark_t turn;
  state_t game_state;
  mark_t winner;
  logic [8:0] win_mask;

  always #5 clk = ~clk;

  ttt_game_ctrl_if mif ();

  ttt_game_ctrl #(
    .BLINK_CYCLES (4),
    .FIRST_MARK   (MARK_X)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .new_game   (new_game),
    .mv         (mif),
    .board      (board),
    .turn       (turn),
    .game_state (game_state),
    .winner     (winner),
    .win_mask   (win_mask)
  );

  int checks = 0;
  int errors = 0;
  string tq[$];
  logic [17:0] vq[$];

  mark_t mb[9];
  mark_t mturn;
  int mcnt;

  function automatic void push(string tag, logic [17:0] v);
    tq.push_back(tag);
    vq.push_back(v);
  endfunction

  task automatic pop_chk(logic [17:0] obs);
    string t;
    logic [17:0] e;
    t = (tq.size() > 0) ? tq.pop_front() : "sb_empty";
    e = (vq.size() > 0) ? vq.pop_front() : 18'h3ffff;
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
    end
  endtask

  function automatic logic [17:0] mboard();
    logic [17:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[2*i +: 2] = mb[i];
    return r;
  endfunction

  function automatic logic [8:0] mwin(mark_t m);
    int ln[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                     '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    logic [8:0] r;
    r = '0;
    for (int l = 0; l < 8; l++) begin
      if (mb[ln[l][0]] == m && mb[ln[l][1]] == m && mb[ln[l][2]] == m) begin
        r[ln[l][0]] = 1'b1;
        r[ln[l][1]] = 1'b1;
        r[ln[l][2]] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [17:0] st_obs();
    return {2'b00, game_state, turn, winner, win_mask, mif.move_ready};
  endfunction

  function automatic logic [17:0] st_exp(state_t s, mark_t t, mark_t w,
                                         logic [8:0] m, logic r);
    return {2'b00, s, t, w, m, r};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) mb[i] = EMPTY;
    mturn = MARK_X;
    mcnt = 0;
  endtask

  task automatic do_move(int c);
    logic legal;
    logic [8:0] w;
    int n;
    legal = (c <= 8) ? (mb[c] == EMPTY) : 1'b0;
    @(negedge clk);
    mif.move_valid = 1'b1;
    mif.move_cell = 4'(c);
    #1;
    n = 0;
    while (!mif.move_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    push("ready_wait", 18'd1);
    pop_chk({17'd0, mif.move_ready});
    @(posedge clk);
    #1 mif.move_valid = 1'b0;
    if (legal) begin
      mb[c] = mturn;
      mcnt++;
    end
    push("board_n1", mboard());
    push("err_n1", {17'd0, !legal});
    push("state_n1", st_exp(legal ? CHECK : PLAY, mturn, EMPTY, 9'd0, !legal));
    @(negedge clk); #1;
    pop_chk(board);
    pop_chk({17'd0, mif.move_err});
    pop_chk(st_obs());
    if (legal) begin
      w = mwin(mturn);
      if (w != 9'd0) push("state_win", st_exp(WIN, mturn, mturn, w, 1'b0));
      else if (mcnt == 9) push("state_draw", st_exp(DRAW, mturn, EMPTY, 9'd0, 1'b0));
      else begin
        mturn = flip(mturn);
        push("state_play", st_exp(PLAY, mturn, EMPTY, 9'd0, 1'b1));
      end
    end else begin
      push("err_clear", 18'd0);
    end
    @(negedge clk); #1;
    pop_chk(legal ? st_obs() : {17'd0, mif.move_err});
  endtask

  task automatic restart();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_reset();
    push("ng_board", 18'd0);
    push("ng_state", st_exp(PLAY, MARK_X, EMPTY, 9'd0, 1'b1));
    #1;
    pop_chk(board);
    pop_chk(st_obs());
  endtask

  initial begin
    logic [17:0] eb;
    reset = 1'b1;
    new_game = 1'b0;
    mif.move_valid = 1'b0;
    mif.move_cell = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    push("rst_board", 18'd0);
    push("rst_state", st_exp(PLAY, MARK_X, EMPTY, 9'd0, 1'b1));
    push("rst_err", 18'd0);
    #1;
    pop_chk(board);
    pop_chk(st_obs());
    pop_chk({17'd0, mif.move_err});

    do_move(4);
    do_move(4);
    do_move(9);

    restart();
    do_move(0); do_move(3); do_move(1); do_move(4); do_move(2);
    for (int k = 0; k < 16; k++) begin
      eb = mboard();
      if (((k / 4) % 2) == 1) eb[5:0] = 6'd0;
      push("blink", eb);
      pop_chk(board);
      @(negedge clk); #1;
    end

    restart();
    do_move(0); do_move(1); do_move(2); do_move(4); do_move(3);
    do_move(5); do_move(7); do_move(6); do_move(8);

    restart();
    do_move(0); do_move(1); do_move(2); do_move(3); do_move(6);
    do_move(5); do_move(8); do_move(7); do_move(4);

    restart();
    do_move(4);
    @(negedge clk);
    new_game = 1'b1;
    mif.move_valid = 1'b1;
    mif.move_cell = 4'd8;
    push("ng_ready", 18'd0);
    #1 pop_chk({17'd0, mif.move_ready});
    @(negedge clk);
    new_game = 1'b0;
    mif.move_valid = 1'b0;
    model_reset();
    push("ng_mv_board", 18'd0);
    push("ng_mv_state", st_exp(PLAY, MARK_X, EMPTY, 9'd0, 1'b1));
    push("ng_mv_err", 18'd0);
    #1;
    pop_chk(board);
    pop_chk(st_obs());
    pop_chk({17'd0, mif.move_err});

    @(negedge clk);
    mif.move_valid = 1'b1;
    mif.move_cell = 4'd2;
    @(posedge clk);
    #1 mif.move_valid = 1'b0;
    @(negedge clk);
    push("rst_chk_state", st_exp(CHECK, MARK_X, EMPTY, 9'd0, 1'b0));
    #1 pop_chk(st_obs());
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    push("rst_mid_board", 18'd0);
    push("rst_mid_state", st_exp(PLAY, MARK_X, EMPTY, 9'd0, 1'b1));
    push("rst_mid_err", 18'd0);
    #1;
    pop_chk(board);
    pop_chk(st_obs());
    pop_chk({17'd0, mif.move_err});

    do_move(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
